// File: rtl/calab_pkg.sv
// Shared definitions for the pipeline control blocks.
//   mem_state_e : states of the memory-wait FSM (IDLE / WAIT / RELEASE)
//   FWD_*       : operand forwarding select encodings
//   reg_match   : true when a stage writes back to the given source register
package calab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  function automatic logic reg_match(input logic       wb_en,
                                     input logic [3:0] dest,
                                     input logic [3:0] src);
    return wb_en && (dest == src);
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait sequencer. Freezes the whole pipeline while a load/store is
// outstanding and remembers a taken branch that arrives during the freeze.
//   clk, rst      : clock, asynchronous active-low reset
//   mem_req       : MEM stage holds a load or store
//   sram_ready    : memory completion strobe
//   branch_taken  : EXE-stage branch resolved taken
//   freeze_all    : freeze every pipeline register
//   pending_flush : a branch was seen while frozen; flush once unfrozen
module mem_wait_fsm
  import calab_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic sram_ready,
  input  logic branch_taken,
  output logic freeze_all,
  output logic pending_flush
);

  mem_state_e state_q, state_d;
  logic       pending_flush_q, pending_flush_d;
  logic       freeze_c;

  always_comb begin
    state_d  = state_q;
    freeze_c = 1'b0;
    case (state_q)
      // A request that completes in the same cycle never needs a freeze.
      ST_IDLE: begin
        if (mem_req && !sram_ready) begin
          state_d  = ST_WAIT;
          freeze_c = 1'b1;
        end
      end
      ST_WAIT: begin
        freeze_c = 1'b1;
        if (sram_ready) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // The pending branch is consumed by the first unfrozen cycle, which is
    // exactly the cycle in which the top issues the deferred flush.
    pending_flush_d = freeze_c ? (pending_flush_q | branch_taken) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  // Mealy output: gated by reset so it reads 0 whatever mem_req does.
  assign freeze_all    = rst & freeze_c;
  assign pending_flush = pending_flush_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: RAW stall detection, operand forwarding selects,
// branch flush, memory-wait freeze and event counters.
//   FORWARD_EN            : 1 = forward from MEM/WB, 0 = stall on every RAW
//   src1, src2, two_src   : ID-stage operands (src2 only valid when two_src)
//   exe_*/mem_*/wb_*      : writeback control of the later stages
//   mem_req, sram_ready   : memory handshake
//   branch_taken          : EXE-stage taken branch
//   hazard_stall, flush, freeze_all, sel_src1, sel_src2 : pipeline control
//   stall_cnt, flush_cnt  : wrapping event counters
module hazard_unit
  import calab_pkg::*;
#(
  parameter int FORWARD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  exe_dest,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dest,
  input  logic        wb_wb_en,
  input  logic [3:0]  wb_dest,
  input  logic        mem_req,
  input  logic        sram_ready,
  input  logic        branch_taken,
  output logic        hazard_stall,
  output logic        flush,
  output logic        freeze_all,
  output logic [1:0]  sel_src1,
  output logic [1:0]  sel_src2,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [3:0]  src [2];
  logic [1:0]  sel [2];
  logic [1:0]  op_used;
  logic [1:0]  hit_exe, hit_mem, hit_wb;
  logic        raw_stall;
  logic        pending_flush;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign src[0]  = src1;
  assign src[1]  = src2;
  assign op_used = {two_src, 1'b1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    assign hit_exe[gi] = op_used[gi] && reg_match(exe_wb_en, exe_dest, src[gi]);
    assign hit_mem[gi] = op_used[gi] && reg_match(mem_wb_en, mem_dest, src[gi]);
    assign hit_wb[gi]  = op_used[gi] && reg_match(wb_wb_en,  wb_dest,  src[gi]);
    // MEM holds the younger value, so it wins over WB.
    assign sel[gi] = ((FORWARD_EN == 0) || !rst) ? FWD_RF  :
                     hit_mem[gi]                 ? FWD_MEM :
                     hit_wb[gi]                  ? FWD_WB  : FWD_RF;
  end

  assign sel_src1 = sel[0];
  assign sel_src2 = sel[1];

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw_stall = (FORWARD_EN != 0) ? (exe_mem_r_en && (|hit_exe))
                                       : ((|hit_exe) || (|hit_mem));

  mem_wait_fsm u_mem_wait_fsm (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .sram_ready    (sram_ready),
    .branch_taken  (branch_taken),
    .freeze_all    (freeze_all),
    .pending_flush (pending_flush)
  );

  // Freeze beats flush, flush beats stall.
  assign flush        = rst && !freeze_all && (branch_taken || pending_flush);
  assign hazard_stall = rst && !freeze_all && !flush && raw_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, (hazard_stall | freeze_all)};
    flush_cnt_d = flush_cnt_q + {15'd0, flush};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: one instance with forwarding, one
// without, sharing all inputs.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] src1, src2, exe_dest, mem_dest, wb_dest;
  logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
  logic       mem_req, sram_ready, branch_taken;

  logic        hs1, fl1, fr1, hs0, fl0, fr0;
  logic [1:0]  sa1, sb1, sa0, sb0;
  logic [31:0] sc1, sc0;
  logic [15:0] fc1, fc0;

  hazard_unit #(.FORWARD_EN(1)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .mem_req(mem_req), .sram_ready(sram_ready), .branch_taken(branch_taken),
    .hazard_stall(hs1), .flush(fl1), .freeze_all(fr1), .sel_src1(sa1), .sel_src2(sb1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_unit #(.FORWARD_EN(0)) dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .mem_req(mem_req), .sram_ready(sram_ready), .branch_taken(branch_taken),
    .hazard_stall(hs0), .flush(fl0), .freeze_all(fr0), .sel_src1(sa0), .sel_src2(sb0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;          // 0 idle, 1 waiting on memory, 2 release cycle
  bit          m_pend;
  logic [31:0] m_sc1, m_sc0;
  logic [15:0] m_fc1, m_fc0;
  bit          e_frz, e_fl, e_st1, e_st0;

  task automatic m_reset();
    m_phase = 0; m_pend = 0;
    m_sc1 = 0; m_sc0 = 0; m_fc1 = 0; m_fc0 = 0;
  endtask

  task automatic check_model();
    logic [3:0] ops [2];
    bit used [2];
    bit any_exe, any_mem, load_use;
    logic [1:0] es [2];
    ops[0] = src1; ops[1] = src2; used[0] = 1; used[1] = two_src;
    any_exe = 0; any_mem = 0;
    e_frz = 0; e_fl = 0; e_st1 = 0; e_st0 = 0;
    es[0] = 2'b00; es[1] = 2'b00;
    if (rst) begin
      e_frz = (m_phase == 1) || (m_phase == 0 && mem_req && !sram_ready);
      e_fl  = !e_frz && (branch_taken || m_pend);
      for (int k = 0; k < 2; k++) begin
        if (used[k]) begin
          if (exe_wb_en && exe_dest == ops[k]) any_exe = 1;
          if (mem_wb_en && mem_dest == ops[k]) any_mem = 1;
          if (mem_wb_en && mem_dest == ops[k])     es[k] = 2'b01;
          else if (wb_wb_en && wb_dest == ops[k])  es[k] = 2'b10;
        end
      end
      load_use = exe_mem_r_en && any_exe;
      e_st1 = !e_frz && !e_fl && load_use;
      e_st0 = !e_frz && !e_fl && (any_exe || any_mem);
    end
    chk("fwd1_stall", hs1, e_st1);    chk("fwd0_stall", hs0, e_st0);
    chk("fwd1_flush", fl1, e_fl);     chk("fwd0_flush", fl0, e_fl);
    chk("fwd1_freeze", fr1, e_frz);   chk("fwd0_freeze", fr0, e_frz);
    chk("fwd1_sel1", sa1, es[0]);     chk("fwd1_sel2", sb1, es[1]);
    chk("fwd0_sel1", sa0, 2'b00);     chk("fwd0_sel2", sb0, 2'b00);
    chk("fwd1_stall_cnt", sc1, m_sc1); chk("fwd0_stall_cnt", sc0, m_sc0);
    chk("fwd1_flush_cnt", fc1, m_fc1); chk("fwd0_flush_cnt", fc0, m_fc0);
  endtask

  task automatic advance();
    if (rst) begin
      m_sc1 = m_sc1 + ((e_st1 || e_frz) ? 1 : 0);
      m_sc0 = m_sc0 + ((e_st0 || e_frz) ? 1 : 0);
      m_fc1 = m_fc1 + (e_fl ? 1 : 0);
      m_fc0 = m_fc0 + (e_fl ? 1 : 0);
      m_pend = e_frz ? (m_pend | branch_taken) : 1'b0;
      case (m_phase)
        0: if (mem_req && !sram_ready) m_phase = 1;
        1: if (sram_ready) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic half();
    @(negedge clk);
    check_model();
  endtask

  task automatic quiet();
    src1 = 0; src2 = 0; two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0;
    mem_wb_en = 0; mem_dest = 0; wb_wb_en = 0; wb_dest = 0;
    mem_req = 0; sram_ready = 0; branch_taken = 0;
  endtask

  // Asynchronous reset assertion, checked before any clock edge.
  task automatic reset_now();
    rst = 1'b0;
    m_reset();
    #1;
    chk("async_rst_freeze", fr1, 0);
    chk("async_rst_stall_cnt", sc1, 0);
    chk("async_rst_flush_cnt", fc1, 0);
    chk("async_rst_stall", hs1, 0);
  endtask

  task automatic release_rst();
    quiet();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] s1, s2; logic two;
    logic exe_wb, exe_rd; logic [3:0] exe_d;
    logic mem_wb; logic [3:0] mem_d;
    logic wb_wb;  logic [3:0] wb_d;
    logic st1; logic [1:0] sel1, sel2; logic st0;
  } vec_t;

  vec_t vt [8];
  int   frz_n;

  initial begin
    //          s1 s2 two exw exr exd mw md ww wd st1 sel1   sel2   st0
    vt[0] = '{4'd3, 4'd0, 0, 1, 1, 4'd3, 0, 4'd0, 0, 4'd0, 1, 2'b00, 2'b00, 1};
    vt[1] = '{4'd0, 4'd5, 1, 0, 0, 4'd0, 1, 4'd5, 1, 4'd5, 0, 2'b00, 2'b01, 1};
    vt[2] = '{4'd0, 4'd5, 0, 0, 0, 4'd0, 1, 4'd5, 1, 4'd5, 0, 2'b00, 2'b00, 0};
    vt[3] = '{4'd7, 4'd2, 1, 0, 0, 4'd0, 1, 4'd2, 1, 4'd7, 0, 2'b10, 2'b01, 1};
    vt[4] = '{4'd9, 4'd0, 0, 1, 0, 4'd9, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 1};
    vt[5] = '{4'd4, 4'd4, 1, 0, 1, 4'd4, 0, 4'd4, 0, 4'd4, 0, 2'b00, 2'b00, 0};
    vt[6] = '{4'd1, 4'd6, 0, 1, 1, 4'd6, 0, 4'd0, 0, 4'd0, 0, 2'b00, 2'b00, 0};
    vt[7] = '{4'd1, 4'd6, 1, 1, 1, 4'd6, 0, 4'd0, 0, 4'd0, 1, 2'b00, 2'b00, 1};

    // Reset held with every input shouting: all outputs must stay 0.
    quiet();
    rst = 1'b0; m_reset();
    mem_req = 1; branch_taken = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1;
    mem_wb_en = 1; mem_dest = 3;
    for (int k = 0; k < 2; k++) begin half(); advance(); end
    release_rst();

    // Table-driven compare / forward vectors.
    for (int i = 0; i < 8; i++) begin
      quiet();
      src1 = vt[i].s1; src2 = vt[i].s2; two_src = vt[i].two;
      exe_wb_en = vt[i].exe_wb; exe_mem_r_en = vt[i].exe_rd; exe_dest = vt[i].exe_d;
      mem_wb_en = vt[i].mem_wb; mem_dest = vt[i].mem_d;
      wb_wb_en = vt[i].wb_wb; wb_dest = vt[i].wb_d;
      half();
      chk($sformatf("vec%0d_stall1", i), hs1, vt[i].st1);
      chk($sformatf("vec%0d_sel1", i), sa1, vt[i].sel1);
      chk($sformatf("vec%0d_sel2", i), sb1, vt[i].sel2);
      chk($sformatf("vec%0d_stall0", i), hs0, vt[i].st0);
      advance();
    end
    // First vector was a load-use stall on a freshly reset counter.
    quiet(); half(); advance();

    // Memory wait: 3 not-ready cycles then ready -> 4 frozen cycles, one release.
    quiet(); frz_n = 0;
    mem_req = 1; sram_ready = 0;
    for (int k = 0; k < 3; k++) begin half(); frz_n += int'(fr1); advance(); end
    sram_ready = 1; half(); frz_n += int'(fr1); advance();
    mem_req = 0; sram_ready = 0; half(); chk("release_freeze", fr1, 0); frz_n += int'(fr1); advance();
    chk("freeze_len", frz_n, 4);
    mem_req = 1; sram_ready = 1; half(); chk("idle_after_release", fr1, 0); advance();
    quiet();

    // Branch during freeze -> deferred single flush.
    reset_now(); release_rst();
    mem_req = 1; sram_ready = 0;
    half(); advance();
    half(); advance();
    branch_taken = 1; half(); chk("flush_during_freeze", fl1, 0); advance();
    branch_taken = 0; sram_ready = 1; half(); chk("flush_during_freeze2", fl1, 0); advance();
    mem_req = 0; sram_ready = 0;
    half(); chk("flush_after_freeze", fl1, 1); chk("freeze_fallen", fr1, 0); advance();
    half(); chk("flush_single", fl1, 0); chk("flush_cnt_one", fc1, 1); advance();

    // Flush overrides a load-use stall.
    src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1; branch_taken = 1;
    half(); chk("flush_over_stall", hs1, 0); chk("flush_over_stall_fl", fl1, 1); advance();
    quiet();

    // Reset in the middle of a wait.
    reset_now(); release_rst();
    mem_req = 1; sram_ready = 0;
    for (int k = 0; k < 7; k++) begin half(); advance(); end
    half(); chk("stall_cnt_seven", sc1, 7); chk("still_frozen", fr1, 1);
    reset_now();
    mem_req = 1; sram_ready = 1;
    @(posedge clk); #1;
    half(); advance();
    rst = 1'b1;
    half(); chk("idle_after_reset", fr1, 0); advance();
    sram_ready = 0; half(); chk("reeval_freeze", fr1, 1); advance();
    mem_req = 0; sram_ready = 1; half(); advance();
    sram_ready = 0; half(); advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
      two_src = 1'($urandom % 2);
      exe_wb_en = 1'($urandom % 2); exe_mem_r_en = 1'($urandom % 2);
      exe_dest = 4'($urandom_range(0, 3));
      mem_wb_en = 1'($urandom % 2); mem_dest = 4'($urandom_range(0, 3));
      wb_wb_en = 1'($urandom % 2);  wb_dest = 4'($urandom_range(0, 3));
      mem_req = ($urandom % 4) == 0;
      sram_ready = 1'($urandom % 2);
      branch_taken = ($urandom % 6) == 0;
      half(); advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
